// File: rtl/cpu_pkg.sv
// Shared constants for the RV32 core: datapath width, reset vector, opcode
// field width and the canonical NOP encoding.
package cpu_pkg;

  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam int              OPCODE_W  = 7;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous circular FIFO of {instr, pc} pairs between the instruction
// memory return path and decode. Flush empties it in one cycle and wins over
// push/pop. Payload storage is never reset; only pointers and count are.
module fetch_queue
#(
  parameter  int QDEPTH = 2,
  parameter  int XLEN   = 32,
  localparam int PTR_W  = $clog2(QDEPTH),
  localparam int CNT_W  = $clog2(QDEPTH + 1)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [XLEN-1:0]  i_instr,
  input  logic [XLEN-1:0]  i_pc,
  output logic [CNT_W-1:0] o_count,
  output logic [XLEN-1:0]  o_head_instr,
  output logic [XLEN-1:0]  o_head_pc
);

  logic [XLEN-1:0]  r_instr [QDEPTH];
  logic [XLEN-1:0]  r_pc    [QDEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !i_flush;
  assign w_pop  = i_pop  && !i_flush;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (QDEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload write at the tail; contents are meaningless until counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wptr] <= i_instr;
      r_pc[r_wptr]    <= i_pc;
    end
  end

  // The upstream credit scheme must never let a word arrive into a full queue.
  always_ff @(posedge clk) begin
    if (!rst && w_push)
      assert (r_count != CNT_W'(QDEPTH))
        else $error("fetch_queue: push into full queue");
  end

  assign o_count      = r_count;
  assign o_head_instr = r_instr[r_rptr];
  assign o_head_pc    = r_pc[r_rptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, tracks the single in-flight request
// to the fixed one-cycle-latency instruction memory, and only issues a request
// when the queue is guaranteed to have room for the returning word.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN     = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int              QDEPTH   = 2
)(
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic [XLEN-1:0]     imem_rdata,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [XLEN-1:0]     if_instr,
  output logic [XLEN-1:0]     if_pc,
  output logic [OPCODE_W-1:0] if_opcode
);

  localparam int CNT_W = $clog2(QDEPTH + 1);

  logic [XLEN-1:0]  r_fetch_pc;
  logic             r_inflight;
  logic [XLEN-1:0]  r_inflight_pc;

  logic [CNT_W-1:0] w_count;
  logic [XLEN-1:0]  w_head_instr;
  logic [XLEN-1:0]  w_head_pc;
  logic             w_valid;
  logic             w_pop;
  logic             w_push;
  logic             w_req;
  logic [CNT_W:0]   w_occ;
  logic [CNT_W:0]   w_limit;

  // A redirect hides the head so nothing stale is consumed during the flush.
  assign w_valid = !rst && !redirect && (w_count != '0);
  assign w_pop   = w_valid && if_ready;
  assign w_push  = r_inflight && !redirect && !rst;

  // Credit check: entries held + word in flight - entry leaving < QDEPTH,
  // rearranged as occ < QDEPTH + pop to stay unsigned.
  assign w_occ   = {1'b0, w_count} + (CNT_W+1)'(r_inflight);
  assign w_limit = (CNT_W+1)'(QDEPTH) + (CNT_W+1)'(w_pop);
  assign w_req   = !rst && !redirect && (w_occ < w_limit);

  // Fetch PC: redirect target is word-aligned; sequential fetch wraps at 2^XLEN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= {RESET_PC[XLEN-1:2], 2'b00};
      r_inflight <= 1'b0;
    end else if (redirect) begin
      r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      r_inflight <= 1'b0;
    end else begin
      if (w_req) r_fetch_pc <= r_fetch_pc + XLEN'(4);
      r_inflight <= w_req;
    end
  end

  // Remember which address the returning word belongs to.
  always_ff @(posedge clk) begin
    if (w_req) r_inflight_pc <= r_fetch_pc;
  end

  fetch_queue #(
    .QDEPTH (QDEPTH),
    .XLEN   (XLEN)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_flush      (redirect),
    .i_instr      (imem_rdata),
    .i_pc         (r_inflight_pc),
    .o_count      (w_count),
    .o_head_instr (w_head_instr),
    .o_head_pc    (w_head_pc)
  );

  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc;
  assign if_valid  = w_valid;
  assign if_instr  = w_valid ? w_head_instr : '0;
  assign if_pc     = w_valid ? w_head_pc    : '0;
  assign if_opcode = if_instr[OPCODE_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a one-cycle imem model returns (addr ^ r_xor), a
// scoreboard queue holds the expected {pc, instr} stream and is checked on
// every accepted decode handshake, and hand-timed sequences plus a redirect
// table check cycle-exact latencies.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  if_opcode;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] r_xor = 32'h0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    int          stall;
    logic [31:0] xr;
  } redir_t;
  redir_t rtab[4];

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_opcode   (if_opcode)
  );

  // Fixed-latency instruction memory: data for a request appears next cycle.
  always @(posedge clk)
    imem_rdata <= imem_req ? (imem_addr ^ r_xor) : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic refill(input logic [31:0] start);
    sb_t e;
    sb.delete();
    for (int i = 0; i < 256; i++) begin
      e.pc    = start + 32'(4 * i);
      e.instr = e.pc ^ r_xor;
      sb.push_back(e);
    end
  endtask

  // Scoreboard: every accepted head must be the next expected {pc, instr}.
  always @(negedge clk) begin : monitor
    sb_t e;
    if (!rst && if_valid && if_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_underflow: got pc %h expected no output", if_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", if_pc, e.pc);
        chk("sb_instr", if_instr, e.instr);
        chk("sb_opcode", {25'd0, if_opcode}, {25'd0, e.instr[6:0]});
      end
    end
  end

  initial begin
    rtab[0] = '{rpc: 32'h0000_0100, exp_addr: 32'h0000_0100, stall: 5, xr: 32'hA5A5_0000};
    rtab[1] = '{rpc: 32'h0000_0103, exp_addr: 32'h0000_0100, stall: 0, xr: 32'h0F0F_0000};
    rtab[2] = '{rpc: 32'hFFFF_FFFC, exp_addr: 32'hFFFF_FFFC, stall: 1, xr: 32'h1234_0000};
    rtab[3] = '{rpc: 32'h0000_2002, exp_addr: 32'h0000_2000, stall: 2, xr: 32'h00FF_0000};

    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; if_ready = 1'b1;
    repeat (3) tick();
    sample();
    chk("rst_req",    {31'd0, imem_req}, 32'd0);
    chk("rst_valid",  {31'd0, if_valid}, 32'd0);
    chk("rst_instr",  if_instr, 32'd0);
    chk("rst_pc",     if_pc, 32'd0);
    chk("rst_opcode", {25'd0, if_opcode}, 32'd0);

    // Reset release: C0 request at RESET_PC, first valid in C2, then no bubbles.
    tick(); rst = 1'b0; refill(32'h0);
    sample();
    chk("c0_req",   {31'd0, imem_req}, 32'd1);
    chk("c0_addr",  imem_addr, 32'h0);
    chk("c0_valid", {31'd0, if_valid}, 32'd0);
    tick(); sample();
    chk("c1_valid", {31'd0, if_valid}, 32'd0);
    chk("c1_addr",  imem_addr, 32'h4);
    for (int k = 0; k < 4; k++) begin
      tick(); sample();
      chk("stream_valid", {31'd0, if_valid}, 32'd1);
      chk("stream_pc", if_pc, 32'(4 * k));
    end

    // Decode stall: queue fills, requests stop, head holds.
    for (int s = 0; s < 5; s++) begin
      tick(); if_ready = 1'b0; sample();
      chk("stall_req",   {31'd0, imem_req}, 32'd0);
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
      chk("stall_pc",    if_pc, 32'h10);
    end
    for (int k = 0; k < 3; k++) begin
      tick(); if_ready = 1'b1; sample();
      chk("release_pc", if_pc, 32'h10 + 32'(4 * k));
    end

    // Redirect table: optional stall first, then redirect in cycle T.
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < rtab[r].stall; s++) begin
        tick(); if_ready = 1'b0;
      end
      tick();
      redirect = 1'b1; redirect_pc = rtab[r].rpc; if_ready = 1'b1;
      r_xor = rtab[r].xr;
      refill(rtab[r].exp_addr);
      sample();
      chk("rd_t_req",   {31'd0, imem_req}, 32'd0);
      chk("rd_t_valid", {31'd0, if_valid}, 32'd0);
      tick(); redirect = 1'b0; sample();
      chk("rd_t1_req",  {31'd0, imem_req}, 32'd1);
      chk("rd_t1_addr", imem_addr, rtab[r].exp_addr);
      chk("rd_t1_valid", {31'd0, if_valid}, 32'd0);
      tick(); sample();
      chk("rd_t2_valid", {31'd0, if_valid}, 32'd0);
      tick(); sample();
      chk("rd_t3_valid", {31'd0, if_valid}, 32'd1);
      chk("rd_t3_pc",    if_pc, rtab[r].exp_addr);
      chk("rd_t3_instr", if_instr, rtab[r].exp_addr ^ rtab[r].xr);
      tick(); sample();
      chk("rd_t4_pc",    if_pc, rtab[r].exp_addr + 32'h4);
    end

    // Back-to-back redirects: the second target wins.
    tick(); redirect = 1'b1; redirect_pc = 32'h400; refill(32'h400);
    sample();
    chk("b2b_t_req", {31'd0, imem_req}, 32'd0);
    tick(); redirect_pc = 32'h800; refill(32'h800);
    sample();
    chk("b2b_t1_req",   {31'd0, imem_req}, 32'd0);
    chk("b2b_t1_valid", {31'd0, if_valid}, 32'd0);
    tick(); redirect = 1'b0; sample();
    chk("b2b_t2_addr", imem_addr, 32'h800);
    tick(); sample();
    chk("b2b_t3_valid", {31'd0, if_valid}, 32'd0);
    tick(); sample();
    chk("b2b_t4_valid", {31'd0, if_valid}, 32'd1);
    chk("b2b_t4_pc",    if_pc, 32'h800);

    // One-cycle reset pulse while streaming.
    repeat (3) tick();
    tick(); rst = 1'b1; sample();
    chk("pulse_valid", {31'd0, if_valid}, 32'd0);
    chk("pulse_req",   {31'd0, imem_req}, 32'd0);
    tick(); rst = 1'b0; refill(32'h0); sample();
    chk("pulse_c0_valid", {31'd0, if_valid}, 32'd0);
    chk("pulse_c0_addr",  imem_addr, 32'h0);
    chk("pulse_c0_req",   {31'd0, imem_req}, 32'd1);
    tick(); sample();
    chk("pulse_c1_valid", {31'd0, if_valid}, 32'd0);
    tick(); sample();
    chk("pulse_c2_valid", {31'd0, if_valid}, 32'd1);
    chk("pulse_c2_pc",    if_pc, 32'h0);
    chk("pulse_c2_instr", if_instr, r_xor);

    // Random decode back-pressure; scoreboard checks order and completeness.
    for (int c = 0; c < 300; c++) begin
      tick(); if_ready = 1'($urandom_range(0, 1));
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
